// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/funct3 encodings and PHT counter type shared by the branch predictor and resolver
package cpu_pkg;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [2:0] F3_BEQ    = 3'b000;
   localparam logic [2:0] F3_BNE    = 3'b001;
   localparam logic [2:0] F3_BLT    = 3'b100;
   localparam logic [2:0] F3_BGE    = 3'b101;
   localparam logic [2:0] F3_BLTU   = 3'b110;
   localparam logic [2:0] F3_BGEU   = 3'b111;
   typedef logic [1:0] pht_ctr_t;
   localparam pht_ctr_t PHT_INIT = 2'b01;
endpackage

// File: rtl/branch_pht.sv
// branch_pht: 2-bit saturating counter table, combinational read of the MSB, one training write port
module branch_pht
   import cpu_pkg::*;
#(
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic             rd_taken_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic             wr_taken_i
);
   pht_ctr_t ctr_q [2**IDX_W];
   pht_ctr_t cur, upd_d;
   assign rd_taken_o = ctr_q[rd_idx_i][1];
   always_comb begin
      cur   = ctr_q[wr_idx_i];
      upd_d = wr_taken_i ? ((cur == 2'b11) ? cur : cur + 2'd1)
                         : ((cur == 2'b00) ? cur : cur - 2'd1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**IDX_W; i++) ctr_q[i] <= PHT_INIT;
      end else if (wr_en_i) begin
         ctr_q[wr_idx_i] <= upd_d;
      end
   end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: EX-stage branch/jump resolution, registered redirect on mispredict, PHT training
module branch_resolver
   import cpu_pkg::*;
#(
   parameter int PHT_IDX_W = 6,
   parameter int XLEN      = 64,
   parameter int PC_W      = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   input  logic            ex_stall,
   input  logic [6:0]      ex_opcode,
   input  logic [2:0]      ex_funct3,
   input  logic [PC_W-1:0] ex_pc,
   input  logic [PC_W-1:0] ex_imm,
   input  logic [XLEN-1:0] ex_rs1_data,
   input  logic [XLEN-1:0] ex_rs2_data,
   input  logic            ex_pred_taken,
   input  logic [PC_W-1:0] lookup_pc,
   output logic            lookup_taken,
   output logic            redirect_valid,
   output logic [PC_W-1:0] redirect_pc,
   output logic [31:0]     br_count,
   output logic [31:0]     mispredict_count
);
   logic            is_br, is_jal, is_jalr, legal_f3, cond, taken;
   logic            resolve, mispredict, count_en, pht_wr;
   logic [PC_W-1:0] jalr_sum, target, fall_pc, redirect_pc_d, redirect_pc_q;
   logic            redirect_valid_q;
   logic [31:0]     br_count_q, br_count_d, mis_count_q, mis_count_d;
   always_comb begin
      is_br      = ex_opcode == OP_BRANCH;
      is_jal     = ex_opcode == OP_JAL;
      is_jalr    = ex_opcode == OP_JALR;
      legal_f3   = ex_funct3[2:1] != 2'b01;
      // funct3[0] inverts the base compare: BEQ/BNE, BLT/BGE, BLTU/BGEU
      cond       = (ex_funct3[2:1] == 2'b00) ? (ex_rs1_data == ex_rs2_data)
                 : (ex_funct3[2:1] == 2'b10) ? ($signed(ex_rs1_data) < $signed(ex_rs2_data))
                 : (ex_rs1_data < ex_rs2_data);
      taken      = is_br ? (cond ^ ex_funct3[0]) : 1'b1;
      jalr_sum   = ex_rs1_data[PC_W-1:0] + ex_imm;
      target     = is_jalr ? {jalr_sum[PC_W-1:1], 1'b0} : ex_pc + ex_imm;
      fall_pc    = ex_pc + 32'd4;
      // wrong-path instruction sitting in EX during the flush cycle is ignored
      resolve    = ex_valid && !ex_stall && !redirect_valid_q && (is_br || is_jal || is_jalr);
      count_en   = resolve && (!is_br || legal_f3);
      pht_wr     = resolve && is_br && legal_f3;
      mispredict = resolve && ((pht_wr && (taken != ex_pred_taken)) || (is_jal && !ex_pred_taken) || is_jalr);
      redirect_pc_d = mispredict ? (taken ? target : fall_pc) : redirect_pc_q;
      br_count_d    = br_count_q + {31'd0, count_en};
      mis_count_d   = mis_count_q + {31'd0, mispredict};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         br_count_q       <= '0;
         mis_count_q      <= '0;
      end else begin
         redirect_valid_q <= mispredict;
         redirect_pc_q    <= redirect_pc_d;
         br_count_q       <= br_count_d;
         mis_count_q      <= mis_count_d;
      end
   end
   branch_pht #(.IDX_W(PHT_IDX_W)) u_pht (
      .clk        (clk),
      .rst        (rst),
      .rd_idx_i   (lookup_pc[PHT_IDX_W+1:2]),
      .rd_taken_o (lookup_taken),
      .wr_en_i    (pht_wr),
      .wr_idx_i   (ex_pc[PHT_IDX_W+1:2]),
      .wr_taken_i (taken)
   );
   assign redirect_valid   = redirect_valid_q;
   assign redirect_pc      = redirect_pc_q;
   assign br_count         = br_count_q;
   assign mispredict_count = mis_count_q;
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed test-plan steps plus random traffic against a behavioural model
module tb_branch_resolver;
   import cpu_pkg::*;
   logic        clk = 1'b0;
   logic        rst, ex_valid, ex_stall, ex_pred_taken;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_pc, ex_imm, lookup_pc;
   logic [63:0] ex_rs1_data, ex_rs2_data;
   logic        lookup_taken, redirect_valid;
   logic [31:0] redirect_pc, br_count, mispredict_count;
   int errors = 0, checks = 0;
   logic [1:0]  m_pht [64];
   logic        m_rv;
   logic [31:0] m_rpc, m_bc, m_mc;
   logic [63:0] pool [6];

   always #5 clk = ~clk;

   branch_resolver dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall),
      .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_pred_taken(ex_pred_taken),
      .lookup_pc(lookup_pc), .lookup_taken(lookup_taken), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .br_count(br_count), .mispredict_count(mispredict_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic s, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [63:0] a, input logic [63:0] b, input logic p);
      ex_valid = v; ex_stall = s; ex_opcode = op; ex_funct3 = f3; ex_pc = pc;
      ex_imm = imm; ex_rs1_data = a; ex_rs2_data = b; ex_pred_taken = p;
   endtask

   task automatic idle();
      drive(0, 0, 7'b0010011, 3'b000, 32'h0, 32'h0, 64'h0, 64'h0, 0);
   endtask

   // What one clock edge must do to the architectural state, from the rules directly
   task automatic model_edge();
      logic tk, mis, cnt, legal;
      logic [31:0] tgt;
      int idx;
      if (rst) begin
         for (int i = 0; i < 64; i++) m_pht[i] = 2'b01;
         m_rv = 0; m_rpc = 0; m_bc = 0; m_mc = 0;
         return;
      end
      tk = 0; mis = 0; cnt = 0; tgt = ex_pc + ex_imm; idx = int'(ex_pc[7:2]);
      if (ex_valid && !ex_stall && !m_rv) begin
         if (ex_opcode == OP_BRANCH) begin
            legal = 1;
            case (ex_funct3)
               F3_BEQ:  tk = ex_rs1_data == ex_rs2_data;
               F3_BNE:  tk = ex_rs1_data != ex_rs2_data;
               F3_BLT:  tk = $signed(ex_rs1_data) < $signed(ex_rs2_data);
               F3_BGE:  tk = $signed(ex_rs1_data) >= $signed(ex_rs2_data);
               F3_BLTU: tk = ex_rs1_data < ex_rs2_data;
               F3_BGEU: tk = ex_rs1_data >= ex_rs2_data;
               default: legal = 0;
            endcase
            if (legal) begin
               cnt = 1;
               mis = tk != ex_pred_taken;
               if (tk && m_pht[idx] != 2'b11) m_pht[idx] = m_pht[idx] + 1;
               if (!tk && m_pht[idx] != 2'b00) m_pht[idx] = m_pht[idx] - 1;
            end
         end else if (ex_opcode == OP_JAL) begin
            tk = 1; cnt = 1; mis = !ex_pred_taken;
         end else if (ex_opcode == OP_JALR) begin
            tk = 1; cnt = 1; mis = 1;
            tgt = (ex_rs1_data[31:0] + ex_imm) & 32'hFFFF_FFFE;
         end
      end
      if (cnt) m_bc = m_bc + 1;
      if (mis) begin
         m_mc = m_mc + 1;
         m_rpc = tk ? tgt : ex_pc + 4;
      end
      m_rv = mis;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check("redirect_valid", 64'(redirect_valid), 64'(m_rv));
      check("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
      check("br_count", 64'(br_count), 64'(m_bc));
      check("mispredict_count", 64'(mispredict_count), 64'(m_mc));
      check("lookup_taken", 64'(lookup_taken), 64'(m_pht[lookup_pc[7:2]][1]));
   endtask

   initial begin
      pool[0] = 64'd0; pool[1] = 64'd1; pool[2] = 64'hFFFF_FFFF_FFFF_FFFF;
      pool[3] = 64'd5; pool[4] = 64'h8000_0000_0000_0000; pool[5] = 64'h7FFF_FFFF_FFFF_FFFF;
      rst = 1; lookup_pc = 32'h100; idle();
      step();
      check("reset_lookup", 64'(lookup_taken), 64'd0);
      rst = 0;
      // 1: mispredicted taken BEQ
      drive(1, 0, OP_BRANCH, F3_BEQ, 32'h100, 32'h20, 64'd5, 64'd5, 0);
      step();
      check("t1_redirect_pc", 64'(redirect_pc), 64'h120);
      check("t1_pht_msb", 64'(lookup_taken), 64'd1);
      idle(); step();
      check("t1_pulse_one_cycle", 64'(redirect_valid), 64'd0);
      // 2: signed vs unsigned compare of -1 and 1
      drive(1, 0, OP_BRANCH, F3_BLT, 32'h200, 32'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1);
      step();
      check("t2_blt_no_redirect", 64'(redirect_valid), 64'd0);
      drive(1, 0, OP_BRANCH, F3_BLTU, 32'h200, 32'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1);
      step();
      check("t2_bltu_fallthrough", 64'(redirect_pc), 64'h204);
      idle(); step();
      // 3: saturate up then train back down
      lookup_pc = 32'h140;
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, OP_BRANCH, F3_BNE, 32'h140, 32'h10, 64'd1, 64'd2, 1);
         step();
      end
      check("t3_saturated_taken", 64'(lookup_taken), 64'd1);
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, OP_BRANCH, F3_BNE, 32'h140, 32'h10, 64'd3, 64'd3, 0);
         step();
      end
      check("t3_back_to_weak_nt", 64'(lookup_taken), 64'd0);
      // 4: JALR redirect, then the wrong-path branch is ignored
      drive(1, 0, OP_JALR, 3'b000, 32'h300, 32'h0, 64'h203, 64'h0, 1);
      step();
      check("t4_jalr_target", 64'(redirect_pc), 64'h202);
      lookup_pc = 32'h380;
      drive(1, 0, OP_BRANCH, F3_BEQ, 32'h380, 32'h8, 64'd0, 64'd0, 0);
      step();
      check("t4_suppressed", 64'(redirect_valid), 64'd0);
      check("t4_pht_untouched", 64'(lookup_taken), 64'd0);
      idle(); step();
      // 5: stalled mispredicting BNE resolves once, after release
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, OP_BRANCH, F3_BNE, 32'h180, 32'h80, 64'd1, 64'd2, 0);
         step();
         check("t5_no_redirect_while_stalled", 64'(redirect_valid), 64'd0);
      end
      drive(1, 0, OP_BRANCH, F3_BNE, 32'h180, 32'h80, 64'd1, 64'd2, 0);
      step();
      check("t5_redirect_after_release", 64'(redirect_pc), 64'h200);
      idle(); step();
      // 6: reset on top of a mispredict, then an illegal funct3
      drive(1, 0, OP_JAL, 3'b000, 32'h400, 32'h100, 64'd0, 64'd0, 0);
      rst = 1; step();
      check("t6_rst_drops_redirect", 64'(redirect_valid), 64'd0);
      check("t6_rst_count", 64'(br_count), 64'd0);
      rst = 0; lookup_pc = 32'h100;
      drive(1, 0, OP_BRANCH, 3'b010, 32'h100, 32'h20, 64'd5, 64'd5, 0);
      step();
      check("t6_illegal_no_count", 64'(br_count), 64'd0);
      // random traffic over a small PC window so PHT entries collide and saturate
      for (int n = 0; n < 600; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
               (r < 6) ? OP_BRANCH : (r == 6) ? OP_JAL : (r == 7) ? OP_JALR : 7'b0110011,
               3'($urandom), {22'd0, 8'($urandom), 2'b00}, $urandom,
               pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)], 1'($urandom));
         ex_rs1_data = ($urandom_range(0, 3) == 0) ? {32'd0, $urandom} : ex_rs1_data;
         lookup_pc = {22'd0, 8'($urandom), 2'b00};
         rst = $urandom_range(0, 99) == 0;
         step();
      end
      rst = 0; idle(); step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
